// File: rtl/rv_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_pkg
// Description : Shared constants and types for the pipeline hazard controller.
//               Stage indices name the producer stages after ALU1 (youngest
//               first). The bypass-select type matches the default stage count.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_hazard_pkg;

    // Producer stage indices, youngest first
    localparam int c_STG_ALU2 = 0;
    localparam int c_STG_MEM  = 1;
    localparam int c_STG_WB   = 2;
    localparam int c_STG_RET  = 3;

    localparam int c_BP_STAGES_DEF = 4;

    // One-hot bypass select; all-zero means "read the register file"
    typedef logic [c_BP_STAGES_DEF-1:0] ctrl_bp_sel_t;

endpackage
`default_nettype wire

// File: rtl/rv_hazard_sb.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_sb
// Description : Register scoreboard for variable-latency writes. One busy bit
//               per architectural register plus a pending-entry count. A
//               set and a clear on the same register in one cycle leaves
//               the bit set and the count unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_hazard_sb #(
    parameter int REG_W       = 5,
    parameter int MAX_PENDING = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_rd,
    input  logic             i_clr_valid,
    input  logic [REG_W-1:0] i_clr_rd,
    input  logic [REG_W-1:0] i_dec_rs1,
    input  logic [REG_W-1:0] i_dec_rs2,
    input  logic [REG_W-1:0] i_dec_rd,
    input  logic             i_dec_long,
    output logic             o_hazard,
    output logic             o_busy,
    output logic             o_full
);
    import rv_hazard_pkg::*;

    localparam int c_NREG  = 2 ** REG_W;
    localparam int c_CNT_W = $clog2(MAX_PENDING + 1);

    logic [c_NREG-1:0]  r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_NREG-1:0]  w_set_vec;
    logic [c_NREG-1:0]  w_clr_vec;
    logic [c_NREG-1:0]  w_busy_eff;
    logic               w_do_clr;
    logic               w_inc;
    logic               w_dec;

    // Completions for registers that are not busy are dropped here
    assign w_do_clr = i_clr_valid & r_busy[i_clr_rd];
    // A set on an already-busy register (the set-wins case) adds no entry
    assign w_inc    = i_set_en & ~r_busy[i_set_rd];
    assign w_dec    = w_do_clr & ~(i_set_en & (i_set_rd == i_clr_rd));

    // Decode one-hot set/clear vectors from the register addresses
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (i_set_en) w_set_vec[i_set_rd] = 1'b1;
        if (w_do_clr) w_clr_vec[i_clr_rd] = 1'b1;
    end

    // Busy bits and pending count; set is applied after clear so it wins
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
            case ({w_inc, w_dec})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // An issue this cycle already blocks a dependent decode
    assign w_busy_eff = r_busy | w_set_vec;

    assign o_full   = (r_cnt == c_CNT_W'(MAX_PENDING));
    assign o_busy   = (r_cnt != '0);
    assign o_hazard = ((i_dec_rs1 != '0) & w_busy_eff[i_dec_rs1])
                    | ((i_dec_rs2 != '0) & w_busy_eff[i_dec_rs2])
                    | ((i_dec_rd  != '0) & w_busy_eff[i_dec_rd])
                    | (i_dec_long & o_full);

endmodule
`default_nettype wire

// File: rtl/rv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_unit
// Description : Pipeline hazard controller. Selects ALU1 operand bypass over
//               BP_STAGES producer stages, stalls on a not-yet-ready nearest
//               producer, tracks long-latency writes in a scoreboard and
//               stretches decode flush after a PC change.
//               Optional: define RV_HAZARD_PERF_EN to add 32-bit stall and
//               flush event counters (o_perf_stall, o_perf_flush).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_hazard_unit #(
    parameter int BP_STAGES    = 4,
    parameter int REG_W        = 5,
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_pc_change,
    input  logic [REG_W-1:0]           i_decode_rs1,
    input  logic [REG_W-1:0]           i_decode_rs2,
    input  logic [REG_W-1:0]           i_decode_rd,
    input  logic                       i_decode_long,
    input  logic [REG_W-1:0]           i_alu1_rs1,
    input  logic [REG_W-1:0]           i_alu1_rs2,
    input  logic [BP_STAGES*REG_W-1:0] i_stg_rd,
    input  logic [BP_STAGES-1:0]       i_stg_reg_write,
    input  logic [BP_STAGES-1:0]       i_stg_data_rdy,
    input  logic                       i_issue_long,
    input  logic [REG_W-1:0]           i_issue_rd,
    input  logic                       i_cmpl_valid,
    input  logic [REG_W-1:0]           i_cmpl_rd,
    output logic [BP_STAGES-1:0]       o_rs1_bp,
    output logic [BP_STAGES-1:0]       o_rs2_bp,
    output logic                       o_decode_stall,
    output logic                       o_decode_flush,
    output logic                       o_alu1_stall,
    output logic                       o_alu1_flush,
    output logic                       o_alu2_flush,
    output logic                       o_sb_busy,
`ifdef RV_HAZARD_PERF_EN
    output logic [31:0]                o_perf_stall,
    output logic [31:0]                o_perf_flush,
`endif
    output logic                       o_sb_full
);
    import rv_hazard_pkg::*;

    localparam int c_FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [c_FW-1:0]      r_fcnt;
    logic [BP_STAGES-1:0] w_rs1_hit;
    logic [BP_STAGES-1:0] w_rs2_hit;
    logic                 w_bp_miss;
    logic                 w_sb_hazard;
    logic                 w_sb_set;

    // Per-stage match of ALU1 operands against producer destinations
    always_comb begin
        w_rs1_hit = '0;
        w_rs2_hit = '0;
        for (int k = 0; k < BP_STAGES; k++) begin
            w_rs1_hit[k] = i_stg_reg_write[k] & (i_alu1_rs1 != '0)
                         & (i_alu1_rs1 == i_stg_rd[k*REG_W +: REG_W]);
            w_rs2_hit[k] = i_stg_reg_write[k] & (i_alu1_rs2 != '0)
                         & (i_alu1_rs2 == i_stg_rd[k*REG_W +: REG_W]);
        end
    end

    // Priority select: scan oldest to youngest so the youngest hit wins
    always_comb begin
        o_rs1_bp = '0;
        o_rs2_bp = '0;
        for (int k = BP_STAGES - 1; k >= 0; k--) begin
            if (w_rs1_hit[k]) begin
                o_rs1_bp    = '0;
                o_rs1_bp[k] = 1'b1;
            end
            if (w_rs2_hit[k]) begin
                o_rs2_bp    = '0;
                o_rs2_bp[k] = 1'b1;
            end
        end
    end

    assign w_bp_miss = (|(o_rs1_bp & ~i_stg_data_rdy))
                     | (|(o_rs2_bp & ~i_stg_data_rdy));

    // Long ops leaving ALU1 are recorded only if they really advance
    assign w_sb_set = i_issue_long & ~i_pc_change & ~w_bp_miss
                    & (i_issue_rd != '0);

    rv_hazard_sb #(
        .REG_W       (REG_W),
        .MAX_PENDING (MAX_PENDING)
    ) u_sb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_set_en    (w_sb_set),
        .i_set_rd    (i_issue_rd),
        .i_clr_valid (i_cmpl_valid),
        .i_clr_rd    (i_cmpl_rd),
        .i_dec_rs1   (i_decode_rs1),
        .i_dec_rs2   (i_decode_rs2),
        .i_dec_rd    (i_decode_rd),
        .i_dec_long  (i_decode_long),
        .o_hazard    (w_sb_hazard),
        .o_busy      (o_sb_busy),
        .o_full      (o_sb_full)
    );

    // Flush countdown; a redirect during the countdown reloads it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fcnt <= '0;
        end else if (i_pc_change) begin
            r_fcnt <= c_FW'(FLUSH_CYCLES - 1);
        end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    assign o_decode_flush = i_pc_change | (r_fcnt != '0);
    assign o_alu1_stall   = w_bp_miss & ~i_pc_change;
    assign o_decode_stall = (w_sb_hazard | w_bp_miss) & ~i_pc_change;
    assign o_alu1_flush   = i_pc_change | (o_decode_stall & ~w_bp_miss);
    assign o_alu2_flush   = i_pc_change | w_bp_miss;

`ifdef RV_HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Free-running event counters, wrap on overflow
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (o_decode_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if (i_pc_change)    r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign o_perf_stall = r_perf_stall;
    assign o_perf_flush = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_hazard_unit
// Description : Self-checking bench for rv_hazard_unit (FLUSH_CYCLES = 3).
//               Combinational bypass cases come from a vector table; the
//               scoreboard, flush and reset behaviour use hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_change;
    logic [4:0]  decode_rs1, decode_rs2, decode_rd;
    logic        decode_long;
    logic [4:0]  alu1_rs1, alu1_rs2;
    logic [19:0] stg_rd;
    logic [3:0]  stg_reg_write, stg_data_rdy;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic        cmpl_valid;
    logic [4:0]  cmpl_rd;
    logic [3:0]  rs1_bp, rs2_bp;
    logic        decode_stall, decode_flush, alu1_stall, alu1_flush, alu2_flush;
    logic        sb_busy, sb_full;
`ifdef RV_HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    always #5 clk = ~clk;

    rv_hazard_unit #(
        .BP_STAGES    (4),
        .REG_W        (5),
        .MAX_PENDING  (4),
        .FLUSH_CYCLES (3)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_pc_change     (pc_change),
        .i_decode_rs1    (decode_rs1),
        .i_decode_rs2    (decode_rs2),
        .i_decode_rd     (decode_rd),
        .i_decode_long   (decode_long),
        .i_alu1_rs1      (alu1_rs1),
        .i_alu1_rs2      (alu1_rs2),
        .i_stg_rd        (stg_rd),
        .i_stg_reg_write (stg_reg_write),
        .i_stg_data_rdy  (stg_data_rdy),
        .i_issue_long    (issue_long),
        .i_issue_rd      (issue_rd),
        .i_cmpl_valid    (cmpl_valid),
        .i_cmpl_rd       (cmpl_rd),
        .o_rs1_bp        (rs1_bp),
        .o_rs2_bp        (rs2_bp),
        .o_decode_stall  (decode_stall),
        .o_decode_flush  (decode_flush),
        .o_alu1_stall    (alu1_stall),
        .o_alu1_flush    (alu1_flush),
        .o_alu2_flush    (alu2_flush),
        .o_sb_busy       (sb_busy),
`ifdef RV_HAZARD_PERF_EN
        .o_perf_stall    (perf_stall),
        .o_perf_flush    (perf_flush),
`endif
        .o_sb_full       (sb_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output word: {rs1_bp, rs2_bp, dstall, dflush, a1stall, a1flush, a2flush, busy, full}
    typedef struct {
        string       name;
        logic [14:0] outs;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [19:0] srd;
        logic [3:0]  rw, rdy;
        logic [3:0]  e_rs1, e_rs2;
        logic        e_a1s, e_ds, e_a1f, e_a2f;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [14:0] mk(input logic [3:0] b1, input logic [3:0] b2,
                                       input logic ds, input logic df, input logic a1s,
                                       input logic a1f, input logic a2f,
                                       input logic bz, input logic fl);
        return {b1, b2, ds, df, a1s, a1f, a2f, bz, fl};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {rs1_bp, rs2_bp, decode_stall, decode_flush, alu1_stall,
                alu1_flush, alu2_flush, sb_busy, sb_full};
    endfunction

    task automatic push(input string name, input logic [14:0] outs);
        exp_t e;
        e.name = name;
        e.outs = outs;
        exp_q.push_back(e);
    endtask

    // Sample away from the driving edge and retire the oldest expectation
    task automatic check();
        exp_t e;
        @(negedge clk);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expectation: got %b required <entry>", dut_outs());
        end else begin
            e = exp_q.pop_front();
            if (dut_outs() !== e.outs) begin
                n_fail++;
                $display("FAIL %s: got %b required %b (rs1bp,rs2bp,dst,dfl,a1s,a1f,a2f,busy,full)",
                         e.name, dut_outs(), e.outs);
            end
        end
    endtask

    task automatic clear_inputs();
        pc_change = 0; decode_rs1 = 0; decode_rs2 = 0; decode_rd = 0; decode_long = 0;
        alu1_rs1 = 0; alu1_rs2 = 0; stg_rd = 0; stg_reg_write = 0; stg_data_rdy = 4'hF;
        issue_long = 0; issue_rd = 0; cmpl_valid = 0; cmpl_rd = 0;
    endtask

    // Advance to just after a rising edge and return to idle inputs
    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        // stg_rd = {rd3, rd2, rd1, rd0}
        tbl[0] = '{5'd5, 5'd0, {5'd0, 5'd5, 5'd0, 5'd5}, 4'b0101, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0, 0};
        tbl[1] = '{5'd0, 5'd7, {5'd0, 5'd0, 5'd0, 5'd7}, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 0, 1};
        tbl[2] = '{5'd0, 5'd7, {5'd0, 5'd0, 5'd0, 5'd7}, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0};
        tbl[3] = '{5'd0, 5'd0, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[4] = '{5'd3, 5'd0, {5'd3, 5'd0, 5'd0, 5'd0}, 4'b1000, 4'b0111, 4'b1000, 4'b0000, 1, 1, 0, 1};
        tbl[5] = '{5'd3, 5'd0, {5'd3, 5'd0, 5'd3, 5'd0}, 4'b1010, 4'b1101, 4'b0010, 4'b0000, 1, 1, 0, 1};
        tbl[6] = '{5'd6, 5'd6, {5'd0, 5'd6, 5'd0, 5'd0}, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 0, 0, 0, 0};
        tbl[7] = '{5'd6, 5'd0, {5'd0, 5'd6, 5'd0, 5'd0}, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[8] = '{5'd4, 5'd8, {5'd8, 5'd0, 5'd4, 5'd0}, 4'b1010, 4'b1111, 4'b0010, 4'b1000, 0, 0, 0, 0};

        rst = 1'b1;
        clear_inputs();
        push("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check();
        cyc();
        rst = 1'b0;

        // Combinational bypass table
        for (int i = 0; i < 9; i++) begin
            cyc();
            alu1_rs1 = tbl[i].rs1; alu1_rs2 = tbl[i].rs2; stg_rd = tbl[i].srd;
            stg_reg_write = tbl[i].rw; stg_data_rdy = tbl[i].rdy;
            push($sformatf("bypass_vec%0d", i),
                 mk(tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_ds, 0, tbl[i].e_a1s,
                    tbl[i].e_a1f, tbl[i].e_a2f, 0, 0));
            check();
        end

        // Scoreboard: issue x9, same-cycle stall, completion releases next cycle
        cyc(); issue_long = 1; issue_rd = 9; decode_rs1 = 9;
        push("sb_issue_same_cycle", mk(0, 0, 1, 0, 0, 1, 0, 0, 0)); check();
        cyc(); decode_rs1 = 9;
        push("sb_pending_rs1", mk(0, 0, 1, 0, 0, 1, 0, 1, 0)); check();
        cyc(); decode_rd = 9;
        push("sb_pending_waw", mk(0, 0, 1, 0, 0, 1, 0, 1, 0)); check();
        cyc(); decode_rs2 = 9; cmpl_valid = 1; cmpl_rd = 9;
        push("sb_cmpl_cycle", mk(0, 0, 1, 0, 0, 1, 0, 1, 0)); check();
        cyc(); decode_rs1 = 9;
        push("sb_released", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        // Issue blocked by a bypass miss is not recorded
        cyc(); issue_long = 1; issue_rd = 13; alu1_rs1 = 7;
        stg_rd = {5'd0, 5'd0, 5'd0, 5'd7}; stg_reg_write = 4'b0001; stg_data_rdy = 4'b0000;
        push("issue_during_miss", mk(4'b0001, 0, 1, 0, 1, 0, 1, 0, 0)); check();
        cyc(); decode_rs1 = 13;
        push("miss_issue_dropped", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        // Fill the scoreboard
        for (int r = 1; r <= 4; r++) begin
            cyc(); issue_long = 1; issue_rd = 5'(r);
            push($sformatf("fill_x%0d", r), mk(0, 0, 0, 0, 0, 0, 0, r > 1, 0)); check();
        end
        cyc(); decode_long = 1; decode_rs1 = 10;
        push("full_long_stalls", mk(0, 0, 1, 0, 0, 1, 0, 1, 1)); check();
        cyc(); decode_rs1 = 10; decode_rs2 = 11; decode_rd = 12;
        push("full_short_ok", mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); check();
        cyc(); cmpl_valid = 1; cmpl_rd = 2; issue_long = 1; issue_rd = 2;
        push("set_wins_cycle", mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); check();
        cyc(); decode_rs1 = 2;
        push("set_wins_bit_kept", mk(0, 0, 1, 0, 0, 1, 0, 1, 1)); check();
        for (int r = 1; r <= 4; r++) begin
            cyc(); cmpl_valid = 1; cmpl_rd = 5'(r);
            push($sformatf("drain_x%0d", r), mk(0, 0, 0, 0, 0, 0, 0, 1, r == 1)); check();
        end
        cyc(); cmpl_valid = 1; cmpl_rd = 20;
        push("drained_empty", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();
        cyc();
        push("stray_cmpl_ignored", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        // Flush stretch; issue on the redirect cycle is dropped
        cyc(); pc_change = 1; issue_long = 1; issue_rd = 9; decode_rs1 = 9;
        push("flush_n", mk(0, 0, 0, 1, 0, 1, 1, 0, 0)); check();
        cyc(); decode_rs1 = 9;
        push("flush_n1", mk(0, 0, 0, 1, 0, 0, 0, 0, 0)); check();
        cyc(); decode_rs1 = 9;
        push("flush_n2", mk(0, 0, 0, 1, 0, 0, 0, 0, 0)); check();
        cyc(); decode_rs1 = 9;
        push("flush_n3_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        // Back-to-back redirects extend the flush window
        cyc(); pc_change = 1;
        push("reflush_m", mk(0, 0, 0, 1, 0, 1, 1, 0, 0)); check();
        cyc(); pc_change = 1;
        push("reflush_m1", mk(0, 0, 0, 1, 0, 1, 1, 0, 0)); check();
        cyc();
        push("reflush_m2", mk(0, 0, 0, 1, 0, 0, 0, 0, 0)); check();
        cyc();
        push("reflush_m3", mk(0, 0, 0, 1, 0, 0, 0, 0, 0)); check();
        cyc();
        push("reflush_m4_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        // Reset with pending entries and an active flush countdown
        for (int r = 1; r <= 3; r++) begin
            cyc(); issue_long = 1; issue_rd = 5'(r);
            push($sformatf("pre_reset_x%0d", r), mk(0, 0, 0, 0, 0, 0, 0, r > 1, 0)); check();
        end
        cyc(); pc_change = 1;
        push("pre_reset_redirect", mk(0, 0, 0, 1, 0, 1, 1, 1, 0)); check();
        cyc(); rst = 1; decode_rs1 = 1;
        push("mid_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();
        cyc(); rst = 0; cmpl_valid = 1; cmpl_rd = 1; decode_rs1 = 1;
        push("post_reset_cmpl", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();
        cyc();
        push("post_reset_cnt0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); check();

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover_expectations: got %0d required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
